// File: rtl/wdt_pkg.sv
// Shared constants and types for the watchdog control block.
package wdt_pkg;

    localparam logic [11:0] WDT_ADDR_WDEN   = 12'h100;
    localparam logic [11:0] WDT_ADDR_WDLIVE = 12'h200;
    localparam logic [11:0] WDT_ADDR_WTOCNT = 12'h300;
    localparam logic [11:0] WDT_ADDR_STATUS = 12'h400;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } wdt_ctrl_state_e;

endpackage

// File: rtl/wdt_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module wdt_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog control registers: enable, stretched kick pulse, timeout compare
// value and sticky timeout interrupt behind a one-outstanding request/response bus.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned LIVE_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        wto_irq
);

    localparam logic [7:0] HOLD_INIT = 8'(LIVE_HOLD);

    wdt_ctrl_state_e state;
    logic [7:0]      hold;
    logic            sticky;
    logic            wto_s;
    logic            access;
    logic            kick, wden_wr, cnt_wr, w1c, err_nx;
    logic [31:0]     rdata_nx;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:12];

    wdt_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (WTO),
        .q   (wto_s)
    );

    assign access    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign WDLIVE    = (hold != '0);
    assign wto_irq   = sticky;

    always_comb begin
        kick     = 1'b0;
        wden_wr  = 1'b0;
        cnt_wr   = 1'b0;
        w1c      = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = '0;
        case (req_addr[11:0])
            WDT_ADDR_WDEN: begin
                if (req_write) wden_wr = req_wstrb[0];
                else           rdata_nx[0] = WDEN;
            end
            WDT_ADDR_WDLIVE: begin
                if (req_write) kick = req_wstrb[0] & req_wdata[0] & WDEN;
                else           rdata_nx[0] = WDLIVE;
            end
            WDT_ADDR_WTOCNT: begin
                if (req_write) begin
                    // compare value is frozen while the watchdog runs
                    if (WDEN) err_nx = 1'b1;
                    else      cnt_wr = 1'b1;
                end else begin
                    rdata_nx = WTOCNT;
                end
            end
            WDT_ADDR_STATUS: begin
                if (req_write) w1c = req_wstrb[0] & req_wdata[0];
                else           rdata_nx[0] = sticky;
            end
            default: err_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            WDEN      <= 1'b0;
            WTOCNT    <= '0;
            hold      <= '0;
            sticky    <= 1'b0;
        end else begin
            // a synchronized timeout in the same cycle as W1C keeps the bit set
            sticky <= wto_s | (sticky & ~(access & w1c));

            if (access && wden_wr) WDEN <= req_wdata[0];

            if (access && wden_wr && !req_wdata[0]) hold <= '0;
            else if (access && kick)                hold <= HOLD_INIT;
            else if (hold != '0)                    hold <= hold - 8'd1;

            if (access && cnt_wr) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (req_wstrb[i]) WTOCNT[8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= RESP;
                        rsp_rdata <= rdata_nx;
                        rsp_err   <= err_nx;
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed self-checking bench for wdt_ctrl.
module tb_wdt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;
    logic        WTO = 1'b0;
    logic        wto_irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        er;

    wdt_ctrl #(.LIVE_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .WDEN      (WDEN),
        .WDLIVE    (WDLIVE),
        .WTOCNT    (WTOCNT),
        .WTO       (WTO),
        .wto_irq   (wto_irq)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL bus_timeout addr=%h rsp_valid=%b required 1", a, rsp_valid);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, WDEN, WDLIVE, WTOCNT, wto_irq} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state ready=%b rvalid=%b rdata=%h err=%b wden=%b live=%b cnt=%h irq=%b required 1 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, WDEN, WDLIVE, WTOCNT, wto_irq);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reg_reads;
        logic [31:0] addrs [3];
        addrs[0] = 32'h100; addrs[1] = 32'h300; addrs[2] = 32'h400;
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, addrs[i], 32'h0, 4'h0, rd, er);
            checks++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                errors++;
                $display("FAIL reset_read addr=%h rdata=%h err=%b required 0 0", addrs[i], rd, er);
            end
        end
    endtask

    task automatic test_wtocnt_lock;
        bus(1'b1, 32'h300, 32'h0000_0100, 4'hF, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0 || WTOCNT !== 32'h100) begin
            errors++;
            $display("FAIL cnt_write err=%b rdata=%h cnt=%h required 0 0 00000100", er, rd, WTOCNT);
        end
        bus(1'b1, 32'h100, 32'h1, 4'h1, rd, er);
        checks++;
        if (er !== 1'b0 || WDEN !== 1'b1) begin
            errors++;
            $display("FAIL wden_set err=%b wden=%b required 0 1", er, WDEN);
        end
        bus(1'b1, 32'h300, 32'h5, 4'hF, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || WTOCNT !== 32'h100) begin
            errors++;
            $display("FAIL cnt_locked err=%b rdata=%h cnt=%h required 1 0 00000100", er, rd, WTOCNT);
        end
        bus(1'b0, 32'h100, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            errors++;
            $display("FAIL wden_read rdata=%h err=%b required 1 0", rd, er);
        end
    endtask

    task automatic kick_run(input logic dbl, input logic [8:0] exp_live);
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (WDLIVE !== exp_live[c]) begin
                errors++;
                $display("FAIL kick_live dbl=%b cycle=%0d live=%b required %b", dbl, c, WDLIVE, exp_live[c]);
            end
            req_valid = (c == 0) || (dbl && c == 2);
            req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h1; req_wstrb = 4'h1;
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_kick;
        logic [8:0] single_exp;
        logic [8:0] double_exp;
        single_exp = 9'b0_0001_1110;
        double_exp = 9'b0_0111_1110;
        kick_run(1'b0, single_exp);
        kick_run(1'b1, double_exp);
        bus(1'b0, 32'h200, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL live_read_idle rdata=%h err=%b required 0 0", rd, er);
        end
        bus(1'b1, 32'h200, 32'h1, 4'h1, rd, er);
        checks++;
        if (WDLIVE !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("FAIL live_after_kick live=%b err=%b required 1 0", WDLIVE, er);
        end
        bus(1'b1, 32'h100, 32'h0, 4'h1, rd, er);
        checks++;
        if (WDLIVE !== 1'b0 || WDEN !== 1'b0) begin
            errors++;
            $display("FAIL wden_clear_kills live=%b wden=%b required 0 0", WDLIVE, WDEN);
        end
        bus(1'b1, 32'h200, 32'h1, 4'h1, rd, er);
        checks++;
        if (er !== 1'b0 || WDLIVE !== 1'b0) begin
            errors++;
            $display("FAIL kick_disabled err=%b live=%b required 0 0", er, WDLIVE);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (WDLIVE !== 1'b0) begin
            errors++;
            $display("FAIL kick_disabled_later live=%b required 0", WDLIVE);
        end
    endtask

    task automatic test_wto;
        @(negedge clk); WTO = 1'b1;
        @(negedge clk); WTO = 1'b0;
        checks++;
        if (wto_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early irq=%b required 0", wto_irq);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wto_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set irq=%b required 1", wto_irq);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wto_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_sticky irq=%b required 1", wto_irq);
        end
        bus(1'b0, 32'h400, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            errors++;
            $display("FAIL status_read rdata=%h err=%b required 1 0", rd, er);
        end
        bus(1'b1, 32'h400, 32'h1, 4'h1, rd, er);
        checks++;
        if (wto_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c irq=%b required 0", wto_irq);
        end
        WTO = 1'b1;
        repeat (4) @(negedge clk);
        bus(1'b1, 32'h400, 32'h1, 4'h1, rd, er);
        checks++;
        if (wto_irq !== 1'b1) begin
            errors++;
            $display("FAIL set_wins irq=%b required 1", wto_irq);
        end
        WTO = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b1, 32'h400, 32'h1, 4'h1, rd, er);
        checks++;
        if (wto_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_w1c_after irq=%b required 0", wto_irq);
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h100 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall cycle=%0d rvalid=%b rdata=%h err=%b ready=%b required 1 00000100 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release rvalid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_bad_addr;
        bus(1'b0, 32'h500, 32'h0, 4'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("FAIL bad_read rdata=%h err=%b required 0 1", rd, er);
        end
        bus(1'b1, 32'h104, 32'h1, 4'hF, rd, er);
        checks++;
        if (er !== 1'b1 || WDEN !== 1'b0 || WTOCNT !== 32'h100) begin
            errors++;
            $display("FAIL bad_write err=%b wden=%b cnt=%h required 1 0 00000100", er, WDEN, WTOCNT);
        end
    endtask

    task automatic test_byte_strobes;
        bus(1'b1, 32'h300, 32'hAABB_CCDD, 4'b0101, rd, er);
        checks++;
        if (er !== 1'b0 || WTOCNT !== 32'h00BB_01DD) begin
            errors++;
            $display("FAIL cnt_strobe err=%b cnt=%h required 0 00bb01dd", er, WTOCNT);
        end
        bus(1'b1, 32'h100, 32'h1, 4'b1110, rd, er);
        checks++;
        if (er !== 1'b0 || WDEN !== 1'b0) begin
            errors++;
            $display("FAIL wden_nostrobe err=%b wden=%b required 0 0", er, WDEN);
        end
    endtask

    task automatic test_reset_mid_kick;
        bus(1'b1, 32'h100, 32'h1, 4'h1, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h1; req_wstrb = 4'h1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (WDLIVE !== 1'b1 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset live=%b rvalid=%b required 1 1", WDLIVE, rsp_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (WDLIVE !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || WDEN !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort live=%b rvalid=%b ready=%b wden=%b required 0 0 1 0",
                     WDLIVE, rsp_valid, req_ready, WDEN);
        end
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (WDLIVE !== 1'b0 || rsp_valid !== 1'b0 || WTOCNT !== 32'h0) begin
            errors++;
            $display("FAIL after_reset live=%b rvalid=%b cnt=%h required 0 0 0", WDLIVE, rsp_valid, WTOCNT);
        end
    endtask

    initial begin
        test_reset;
        test_reg_reads;
        test_wtocnt_lock;
        test_kick;
        test_wto;
        test_stall;
        test_bad_addr;
        test_byte_strobes;
        test_reset_mid_kick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_ctrl.md
WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 Parameter LIVE_HOLD, default 4, meaning number of clk cycles WDLIVE stays high after one kick write (legal range 1..255).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  bus request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address; only bits [11:0] decoded.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_wstrb  input  4  byte enables for writes.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  requester accepts the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  access rejected.
REQ-014 WDEN  output  1  watchdog enable to the timer.
REQ-015 WDLIVE  output  1  kick pulse to the timer, stretched.
REQ-016 WTOCNT  output  32  timeout compare value to the timer.
REQ-017 WTO  input  1  timeout level from the timer, asynchronous to clk.
REQ-018 wto_irq  output  1  sticky timeout interrupt.

Function
REQ-019 FSM has two states: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-020 IDLE -> RESP on the cycle req_valid=1; the access takes effect on that same clock edge.
REQ-021 RESP -> IDLE on the cycle rsp_ready=1. rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Register map:
- 0x100 WDEN: bit0, R/W.
- 0x200 WDLIVE: write with bit0=1 starts a kick; read bit0 = WDLIVE.
- 0x300 WTOCNT: R/W; per-byte wstrb.
- 0x400 STATUS: bit0 = sticky timeout; write-1-to-clear.
REQ-023 Writes to 0x100, 0x200 and 0x400 act only when wstrb[0]=1.
REQ-024 Access to any undecoded address returns rsp_err=1 and rsp_rdata=0, with no side effect.
REQ-025 A write to WTOCNT while WDEN=1 is ignored and returns rsp_err=1.
REQ-026 A write to 0x100 that changes WDEN and also writes WTOCNT is not possible (separate addresses); WTOCNT is the new value on the cycle after its write.
REQ-027 Kick start: hold counter loads LIVE_HOLD and WDLIVE=1 from the next cycle for exactly LIVE_HOLD cycles.
REQ-028 A kick issued while WDLIVE=1 reloads the counter to LIVE_HOLD; there is no gap in WDLIVE.
REQ-029 A kick is ignored while WDEN=0 (rsp_err=0, no pulse).
REQ-030 WDEN written 0 forces WDLIVE=0 and the hold counter to 0 on the next cycle.
REQ-031 WTO passes through a 2-flop synchronizer. The sticky bit sets while the synchronized WTO=1.
REQ-032 If a sticky set and a W1C occur in the same cycle, set wins.
REQ-033 wto_irq equals the sticky bit.
REQ-034 The sticky bit is not cleared by WDEN=0 or by a kick; it clears only on W1C or reset.

Reset
REQ-035 While rst=0 the following hold:
- state = IDLE, req_ready=1.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- WDEN=0, WDLIVE=0, WTOCNT=0.
- hold counter=0, synchronizer flops=0, sticky=0, wto_irq=0.
REQ-036 Reset asserted mid-response or mid-kick aborts it immediately; no response is delivered after release.

Structure
REQ-037 Package wdt_pkg holds:
- address constants WDT_ADDR_WDEN, WDT_ADDR_WDLIVE, WDT_ADDR_WTOCNT and WDT_ADDR_STATUS.
- state enum wdt_ctrl_state_e {IDLE, RESP}.
REQ-038 The synchronizer is a sub-module, wdt_sync2 (parameterless, 1-bit, clk/rst).

Verification
REQ-039 Reset, then read 0x100, 0x300 and 0x400 -> each returns rdata=0, err=0.
REQ-040 Write 0x300=0x0000_0100, write 0x100=1, then write 0x300=5 -> WTOCNT stays 0x100 and the second write returns err=1.
REQ-041 With WDEN=1, kick at cycle t -> WDLIVE high for cycles t+1..t+4. A second kick at t+2 extends WDLIVE through t+6.
REQ-042 Drive WTO=1 for 1 cycle -> wto_irq=1 at 2–3 cycles later and stays 1 after WTO drops. Write 0x400=1 -> wto_irq=0 next cycle.
REQ-043 Hold rsp_ready=0 for 5 cycles after a read of 0x300 -> rsp_valid and rdata are stable and req_ready=0 throughout. A read of 0x500 -> err=1, rdata=0.
REQ-044 Assert rst during a kick -> WDLIVE=0 immediately and remains 0 after release.
